// File: rtl/clock_in_monitor.sv
// Frequency and lock monitor for a forwarded clock.
// Counts synchronized clk_meas rising edges over fixed gate windows of clk.
module clock_in_monitor #(
    parameter int GATE_CYCLES  = 100,
    parameter int CNT_W        = 16,
    parameter int MIN_COUNT    = 20,
    parameter int MAX_COUNT    = 30,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_meas,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_valid,
    output logic             in_range,
    output logic             locked,
    output logic             lock_lost
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int WW = $clog2(LOCK_WINDOWS + 1);

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQUIRE,
        LOCKED
    } state_e;

    state_e           state_q;
    logic             meas_s1_q;
    logic             meas_s2_q;
    logic             meas_dly_q;
    logic [GW-1:0]    gate_q;
    logic [GW-1:0]    gate_d;
    logic [CNT_W-1:0] edge_q;
    logic [CNT_W-1:0] edge_d;
    logic [CNT_W-1:0] cnt_fin;
    logic [WW-1:0]    win_q;
    logic [WW-1:0]    win_nx;
    logic             edge_det;
    logic             win_end;
    logic             hit;

    assign edge_det = meas_s2_q & ~meas_dly_q;
    assign win_end  = (gate_q == GW'(GATE_CYCLES - 1));
    assign gate_d   = win_end ? '0 : gate_q + 1'b1;

    // Final count includes an edge landing on the window-end cycle.
    assign cnt_fin  = (edge_det && !(&edge_q)) ? edge_q + 1'b1 : edge_q;
    assign edge_d   = win_end ? '0 : cnt_fin;
    assign win_nx   = win_q + 1'b1;

    assign hit = (32'(cnt_fin) >= 32'(MIN_COUNT)) &&
                 (32'(cnt_fin) <= 32'(MAX_COUNT));

    always_ff @(posedge clk) begin
        if (rst) begin
            meas_s1_q  <= 1'b0;
            meas_s2_q  <= 1'b0;
            meas_dly_q <= 1'b0;
        end else begin
            meas_s1_q  <= clk_meas;
            meas_s2_q  <= meas_s1_q;
            meas_dly_q <= meas_s2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_q     <= '0;
            edge_q     <= '0;
            freq_count <= '0;
            freq_valid <= 1'b0;
            in_range   <= 1'b0;
            locked     <= 1'b0;
            lock_lost  <= 1'b0;
            win_q      <= '0;
            state_q    <= UNLOCKED;
        end else begin
            gate_q     <= gate_d;
            edge_q     <= edge_d;
            freq_valid <= win_end;
            lock_lost  <= 1'b0;
            if (win_end) begin
                freq_count <= cnt_fin;
                in_range   <= hit;
                unique case (state_q)
                    UNLOCKED: begin
                        if (hit) begin
                            win_q <= WW'(1);
                            if (LOCK_WINDOWS == 1) begin
                                state_q <= LOCKED;
                                locked  <= 1'b1;
                            end else begin
                                state_q <= ACQUIRE;
                            end
                        end else begin
                            win_q <= '0;
                        end
                    end
                    ACQUIRE: begin
                        if (hit) begin
                            win_q <= win_nx;
                            if (32'(win_nx) >= 32'(LOCK_WINDOWS)) begin
                                state_q <= LOCKED;
                                locked  <= 1'b1;
                            end
                        end else begin
                            state_q <= UNLOCKED;
                            win_q   <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!hit) begin
                            state_q   <= UNLOCKED;
                            win_q     <= '0;
                            locked    <= 1'b0;
                            lock_lost <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= UNLOCKED;
                        win_q   <= '0;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/clock_in_monitor.md
CLOCK_IN_MONITOR -- requirements
Module: clock_in_monitor

Interface
REQ-001 The module SHALL have parameter GATE_CYCLES, default 100, meaning the number of clk cycles in one measurement window (minimum 4).
REQ-002 The module SHALL have parameter CNT_W, default 16, meaning the width of the edge count.
REQ-003 The module SHALL have parameter MIN_COUNT, default 20, meaning the lowest edge count accepted as in-range.
REQ-004 The module SHALL have parameter MAX_COUNT, default 30, meaning the highest edge count accepted as in-range.
REQ-005 The module SHALL have parameter LOCK_WINDOWS, default 4, meaning the number of consecutive in-range windows needed for lock (minimum 1).
REQ-006 The module SHALL have port clk, input, width 1, carrying the system clock; all logic is on its rising edge.
REQ-007 The module SHALL have port rst, input, width 1, carrying a synchronous, active-high reset.
REQ-008 The module SHALL have port clk_meas, input, width 1, carrying the incoming forwarded clock, which is asynchronous to clk and below clk/2.
REQ-009 The module SHALL have port freq_count, output, width CNT_W, holding the rising-edge count of the last completed window.
REQ-010 The module SHALL have port freq_valid, output, width 1, pulsing for one cycle when freq_count updates.
REQ-011 The module SHALL have port in_range, output, width 1, indicating that the last window count lies within [MIN_COUNT, MAX_COUNT].
REQ-012 The module SHALL have port locked, output, width 1, indicating that the clock is present and stable per the lock FSM.
REQ-013 The module SHALL have port lock_lost, output, width 1, pulsing for one cycle on the LOCKED -> UNLOCKED transition.

Function
REQ-014 clk_meas SHALL pass through a 2-flop synchronizer, then a third flop; a rising edge is detected when sync=1 and delayed=0.
REQ-015 A gate counter SHALL count 0..GATE_CYCLES-1, then wrap to 0; the window ends on the cycle where the gate counter equals GATE_CYCLES-1.
REQ-016 An edge counter SHALL increment on each detected edge and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-017 An edge detected on the window-end cycle SHALL be counted in the ending window.
REQ-018 On the window-end cycle the edge counter SHALL reset to 0, except that an edge on that cycle is not carried into the next window.
REQ-019 On the cycle after window end, freq_count SHALL hold the final count of that window, and freq_valid SHALL be 1 for exactly that one cycle.
REQ-020 in_range SHALL update on the same cycle as freq_count.
REQ-021 in_range SHALL be a registered compare MIN_COUNT <= count <= MAX_COUNT, inclusive at both bounds.
REQ-022 The lock FSM SHALL have states UNLOCKED, ACQUIRE and LOCKED, and a window counter win_cnt; it evaluates only on window-end results, once per window.
REQ-023 In UNLOCKED, an in-range window SHALL move the FSM to ACQUIRE with win_cnt=1, or directly to LOCKED if LOCK_WINDOWS=1.
REQ-024 In UNLOCKED, an out-of-range window SHALL keep the FSM in UNLOCKED.
REQ-025 In ACQUIRE, an in-range window SHALL increment win_cnt.
REQ-026 In ACQUIRE, the FSM SHALL move to LOCKED when win_cnt reaches LOCK_WINDOWS.
REQ-027 In ACQUIRE, an out-of-range window SHALL return the FSM to UNLOCKED with win_cnt=0.
REQ-028 In LOCKED, an in-range window SHALL keep the FSM in LOCKED.
REQ-029 In LOCKED, a single out-of-range window SHALL move the FSM to UNLOCKED and pulse lock_lost for 1 cycle.
REQ-030 locked SHALL be 1 only in LOCKED, and SHALL change on the same cycle as freq_valid.
REQ-031 With clk_meas stuck at 0 or at 1, count=0 SHALL be reported, so in_range=0 when MIN_COUNT>0.
REQ-032 The window sequence SHALL free-run continuously and SHALL have no enable.

Reset
REQ-033 When rst=1 at a clk edge, freq_count SHALL be 0.
REQ-034 When rst=1 at a clk edge, freq_valid SHALL be 0.
REQ-035 When rst=1 at a clk edge, in_range SHALL be 0.
REQ-036 When rst=1 at a clk edge, locked SHALL be 0.
REQ-037 When rst=1 at a clk edge, lock_lost SHALL be 0.
REQ-038 When rst=1 at a clk edge, the FSM SHALL be in UNLOCKED.
REQ-039 When rst=1 at a clk edge, the gate counter, the edge counter, win_cnt and the synchronizer flops SHALL all be 0.
REQ-040 Reset asserted mid-window SHALL discard the partial window; the first window after reset release SHALL be a full GATE_CYCLES window.
REQ-041 Reset asserted while LOCKED SHALL clear locked without pulsing lock_lost.

Verification
REQ-042 The bench SHALL cover: defaults, clk_meas = clk/4 -> freq_count=25 with a freq_valid pulse every 100 cycles, in_range=1, and locked=1 after the 4th window.
REQ-043 The bench SHALL cover: clk_meas held at 0 -> freq_count=0, in_range=0, locked never asserts.
REQ-044 The bench SHALL cover: locked at clk/4, then clk_meas switched to clk/10 -> the next full window has count=10, locked falls, and lock_lost pulses exactly once.
REQ-045 The bench SHALL cover: clk/4 for 2 windows, one window at clk/10, then clk/4 -> the FSM returns to UNLOCKED, and locked asserts only after 4 further consecutive in-range windows.
REQ-046 The bench SHALL cover: boundary counts of 20 and 30 give in_range=1, and counts of 19 and 31 give in_range=0.
REQ-047 The bench SHALL cover: CNT_W=4 with clk/4 -> freq_count saturates at 15, and rst pulsed mid-window while locked -> all outputs 0, no lock_lost pulse, and the next freq_valid arrives GATE_CYCLES+1 cycles after rst release.
